// File: rtl/sig_wr.sv
// rtl/sig_wr.sv - last-address signalling bus write initiator with ack timeout and idle gap
// Optional single retry after a timeout is built when SIG_WR_RETRY_EN is defined.

`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif

module sig_wr #(
  parameter int ADR_WIDTH = `ADR_WIDTH,
  parameter int DAT_WIDTH = 32,
  parameter int TIMEOUT   = 16,
  parameter int GAP       = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [DAT_WIDTH-1:0] req_dat_i,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  input  logic                 ack_i,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW      = $clog2(GAP_EFF + 1);
  localparam logic [TW-1:0] TO_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e                 state_q;
  logic [TW-1:0]          tcnt_q;
  logic [GW-1:0]          gcnt_q;
  logic                   ready_q;
  logic                   cyc_q;
  logic                   done_q;
  logic                   err_q;
  logic [ADR_WIDTH-1:0]   adr_q;
  logic [DAT_WIDTH-1:0]   dat_q;
  logic                   timeout_hit;

`ifdef SIG_WR_RETRY_EN
  logic [DAT_WIDTH-1:0]   cap_q;
  logic                   retry_q;
  logic                   reissue_q;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      gcnt_q    <= '0;
      ready_q   <= 1'b0;
      cyc_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
`ifdef SIG_WR_RETRY_EN
      cap_q     <= '0;
      retry_q   <= 1'b0;
      reissue_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // ready rises on the first edge after reset without accepting anything yet
          ready_q <= 1'b1;
          if (req_valid_i && ready_q) begin
            state_q   <= S_WRITE;
            ready_q   <= 1'b0;
            cyc_q     <= 1'b1;
            adr_q     <= '1;
            dat_q     <= req_dat_i;
            tcnt_q    <= '0;
`ifdef SIG_WR_RETRY_EN
            cap_q     <= req_dat_i;
            retry_q   <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          if (TIMEOUT != 0) tcnt_q <= tcnt_q + 1'b1;
          if (ack_i || timeout_hit) begin
            state_q <= S_GAP;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            gcnt_q  <= '0;
            if (ack_i) begin
              done_q <= 1'b1;
            end else begin
`ifdef SIG_WR_RETRY_EN
              if (retry_q) begin
                err_q <= 1'b1;
              end else begin
                retry_q   <= 1'b1;
                reissue_q <= 1'b1;
              end
`else
              err_q <= 1'b1;
`endif
            end
          end
        end
        S_GAP: begin
          if (gcnt_q == GAP_LAST) begin
`ifdef SIG_WR_RETRY_EN
            if (reissue_q) begin
              reissue_q <= 1'b0;
              state_q   <= S_WRITE;
              cyc_q     <= 1'b1;
              adr_q     <= '1;
              dat_q     <= cap_q;
              tcnt_q    <= '0;
            end else begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
`else
            state_q <= S_IDLE;
            ready_q <= 1'b1;
`endif
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          cyc_q   <= 1'b0;
          adr_q   <= '0;
          dat_q   <= '0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = cyc_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  a_done_err_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(done_q && err_q));

endmodule

// File: tb/tb_sig_wr.sv
// tb/tb_sig_wr.sv - self-checking bench for sig_wr: vector table, corner sequences, random vs model

module tb_sig_wr;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int TO_A  = 4;
  localparam int GAP_A = 1;
  localparam int GAP_B = 3;
  localparam int INF   = 1 << 30;
`ifdef SIG_WR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_valid = 0, a_ack = 0, a_ready, a_cyc, a_stb, a_we, a_done, a_err;
  logic [DW-1:0] a_dat_in = '0, a_dat;
  logic [AW-1:0] a_adr;
  logic          b_valid = 0, b_ack = 0, b_ready, b_cyc, b_stb, b_we, b_done, b_err;
  logic [DW-1:0] b_dat_in = '0, b_dat;
  logic [AW-1:0] b_adr;

  sig_wr #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO_A), .GAP(GAP_A)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_dat_i(a_dat_in), .cyc_o(a_cyc), .stb_o(a_stb), .we_o(a_we), .adr_o(a_adr),
    .dat_o(a_dat), .ack_i(a_ack), .done_o(a_done), .err_o(a_err));

  sig_wr #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TO_A), .GAP(GAP_B)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_dat_i(b_dat_in), .cyc_o(b_cyc), .stb_o(b_stb), .we_o(b_we), .adr_o(b_adr),
    .dat_o(b_dat), .ack_i(b_ack), .done_o(b_done), .err_o(b_err));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_a(input string tag, input logic r, input logic c, input logic dn,
                       input logic er, input logic [DW-1:0] d);
    chk({tag, "_ready"}, a_ready, r);
    chk({tag, "_cyc"},   a_cyc,   c);
    chk({tag, "_stb"},   a_stb,   c);
    chk({tag, "_we"},    a_we,    c);
    chk({tag, "_adr"},   a_adr,   c ? {AW{1'b1}} : {AW{1'b0}});
    chk({tag, "_dat"},   a_dat,   c ? d : '0);
    chk({tag, "_done"},  a_done,  dn);
    chk({tag, "_err"},   a_err,   er);
  endtask

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          a;
    logic          r;
    logic          c;
    logic          dn;
    logic          er;
    logic [DW-1:0] dat;
  } vec_t;

  function automatic vec_t mk(logic v, logic [DW-1:0] d, logic a, logic r, logic c,
                              logic dn, logic er, logic [DW-1:0] dat);
    vec_t x;
    x.v = v; x.d = d; x.a = a; x.r = r; x.c = c; x.dn = dn; x.er = er; x.dat = dat;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int n;
    int last, writes, dones;
    logic [DW-1:0] cap;
    int t_write, ready_from, done_at, err_at;
    bit retried, exp_ready, exp_bus;

    // inputs of a row apply during that cycle; expectations describe the same cycle
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 32'hDEADBEEF, 1, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(1, 32'hA5A50F0F, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h11111111, 0, 0, 1, 0, 0, 32'hA5A50F0F));
    tbl.push_back(mk(0, 32'h22222222, 0, 0, 1, 0, 0, 32'hA5A50F0F));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, 0, 0, 32'hA5A50F0F));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 32'hA5A50F0F));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(1, 32'h12345678, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 32'h12345678));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(1, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 0, 0, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 0, 0, 0, 32'h0));

    rst_n = 1'b0;
    a_valid = 1; a_dat_in = 32'hFFFF0000; a_ack = 1;
    step(); step(); step();
    chk_a("reset", 0, 0, 0, 0, '0);
    chk("reset_b_ready", b_ready, 0);
    chk("reset_b_cyc", b_cyc, 0);
    a_valid = 0; a_ack = 0;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      chk_a($sformatf("row%0d", i), tbl[i].r, tbl[i].c, tbl[i].dn, tbl[i].er, tbl[i].dat);
      a_valid = tbl[i].v; a_dat_in = tbl[i].d; a_ack = tbl[i].a;
      step();
    end

    // timeout: TIMEOUT=4 with ack held low
    chk("to_ready", a_ready, 1);
    a_valid = 1; a_dat_in = 32'h5A5AC3C3; a_ack = 0;
    step();
    a_valid = 0; a_dat_in = 32'h0;
    n = 0;
    while (a_cyc && n < 20) begin
      chk("to_dat", a_dat, 32'h5A5AC3C3);
      chk("to_done_low", a_done, 0);
      step();
      n++;
    end
    chk("to_len", n, TO_A);
    if (RETRY) begin
      chk("to_retry_no_err", a_err, 0);
      chk("to_retry_gap_cyc", a_cyc, 0);
      step();
      n = 0;
      while (a_cyc && n < 20) begin
        chk("to_retry_dat", a_dat, 32'h5A5AC3C3);
        step();
        n++;
      end
      chk("to_retry_len", n, TO_A);
    end
    chk("to_err", a_err, 1);
    chk("to_err_done", a_done, 0);
    chk("to_err_cyc", a_cyc, 0);
    chk("to_err_adr", a_adr, 0);
    step();
    chk("to_err_pulse", a_err, 0);
    chk("to_ready_again", a_ready, 1);

    // back-to-back on GAP=3 instance, ack always high
    b_valid = 1; b_ack = 1; b_dat_in = 32'h0F0F0001;
    last = -1; writes = 0; dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 45) b_valid = 0;
      step();
      if (b_cyc) begin
        if (last >= 0) chk("b2b_spacing", i - last, GAP_B + 2);
        chk("b2b_adr", b_adr, {AW{1'b1}});
        last = i;
        writes++;
      end
      if (b_done) dones++;
      chk("b2b_no_err", b_err, 0);
    end
    chk("b2b_writes", writes, 9);
    chk("b2b_dones", dones, 9);
    b_ack = 0;

    // reset in the second WRITE cycle
    n = 0;
    while (!a_ready && n < 20) begin step(); n++; end
    chk("rst_pre_ready", a_ready, 1);
    a_valid = 1; a_dat_in = 32'h0BADF00D; a_ack = 0;
    step();
    a_valid = 0;
    chk("rst_w1_cyc", a_cyc, 1);
    step();
    chk("rst_w2_cyc", a_cyc, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("rst_async", 0, 0, 0, 0, '0);
    step();
    chk_a("rst_hold", 0, 0, 0, 0, '0);
    step();
    rst_n = 1'b1;
    chk("rst_rel_ready", a_ready, 0);
    step();
    chk_a("rst_after", 1, 0, 0, 0, '0);

    // random traffic against a timestamp model
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ready_from = cyc + 1; t_write = -1; done_at = -1; err_at = -1; retried = 0; cap = '0;
    for (int k = 0; k < 1500; k++) begin
      exp_ready = (cyc >= ready_from);
      exp_bus   = (t_write >= 0) && (cyc >= t_write);
      chk_a($sformatf("rnd%0d", k), exp_ready, exp_bus, cyc == done_at, cyc == err_at, cap);
      a_valid  = ($urandom_range(0, 2) == 0);
      a_dat_in = $urandom;
      a_ack    = ($urandom_range(0, 3) == 0);
      if (exp_ready && a_valid) begin
        cap = a_dat_in; t_write = cyc + 1; retried = 0; ready_from = INF;
      end else if (exp_bus) begin
        if (a_ack) begin
          done_at = cyc + 1; t_write = -1; ready_from = cyc + 1 + GAP_A;
        end else if (cyc - t_write == TO_A - 1) begin
          if (RETRY && !retried) begin
            retried = 1; t_write = cyc + 1 + GAP_A;
          end else begin
            err_at = cyc + 1; t_write = -1; ready_from = cyc + 1 + GAP_A;
          end
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sig_wr.md
Name: sig_wr

Overview:
- Bus write initiator that issues the "last address" signalling write: a write to the all-ones address, carrying a data word.
- Sits beside the CPU as a second bus initiator, used by test and control logic to raise halt/event signals that the address-write detector on the bus recognises.
- Accepts requests through a valid/ready handshake and runs one bus write per request.
- After every write it enforces an idle gap, so each write produces a distinct falling edge of the adr-all-ones-and-we condition.

Parameters:
- ADR_WIDTH, default `ADR_WIDTH (codebase header), bus address width.
- DAT_WIDTH, default 32, bus data width.
- TIMEOUT, default 16: cycles to wait for ack_i before abandoning the write. 0 = wait forever.
- GAP, default 1: idle cycles after each write. Values below 1 are treated as 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_dat_i  in  DAT_WIDTH  data for the signalling write.
- cyc_o  out  1  bus cycle active.
- stb_o  out  1  bus strobe.
- we_o  out  1  write enable.
- adr_o  out  ADR_WIDTH  bus address.
- dat_o  out  DAT_WIDTH  bus write data.
- ack_i  in  1  bus acknowledge.
- done_o  out  1  one-cycle pulse: write acknowledged.
- err_o  out  1  one-cycle pulse: write timed out.

Behaviour:
- Clock and reset: clock is clk_i. Reset is asynchronous, active-low.
- Reset values: all outputs and state registers are registered. While rst_ni=0: cyc_o, stb_o, we_o, done_o, err_o = 0; adr_o = 0; dat_o = 0; req_ready_o = 0; FSM = IDLE; counters = 0.
- FSM states:
  - IDLE: req_ready_o=1, bus outputs 0. A handshake at edge N captures req_dat_i and moves to WRITE. From edge N+1: cyc_o=stb_o=we_o=1, adr_o=all ones, dat_o=captured data, req_ready_o=0.
  - WRITE: outputs held stable. Cycle counter starts at 0 and increments each cycle.
    - ack_i=1 sampled: next cycle → GAP, done_o=1 for exactly one cycle.
    - Otherwise, if TIMEOUT≠0 and counter==TIMEOUT-1: next cycle → GAP, err_o=1 for one cycle.
    - ack_i and timeout in the same cycle: ack wins (done_o, no err_o).
  - GAP: cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, req_ready_o=0 for exactly GAP cycles, then → IDLE.
- ack_i outside WRITE is ignored.
- Latency:
  - Minimum accept-to-accept spacing is 1 (IDLE) + 1 (WRITE with immediate ack) + GAP cycles.
  - An immediate ack means ack_i high in the first WRITE cycle. With GAP=1: request at N, bus active N+1, done_o at N+2, ready again at N+3.
- Data path: req_dat_i is sampled only on a handshake. Changes on req_dat_i during WRITE have no effect.
- Counter width: clog2(TIMEOUT+1), minimum 1 bit. GAP counter: clog2(GAP+1).
- Reset mid-operation: bus outputs drop to 0 immediately (asynchronously). The in-flight write is abandoned and neither done_o nor err_o is pulsed. After release the FSM is in IDLE.
- done_o and err_o are never high together.

Optional Feature:
- Macro: SIG_WR_RETRY_EN.
- Defined: on the first timeout of a request, no err_o. The FSM goes through GAP, then reissues the same captured data once (WRITE again, counter cleared).
  - err_o pulses only if the retry also times out.
  - done_o pulses if the retry is acknowledged.
  - A 1-bit retry flag clears on each new handshake and on reset.
- Not defined: err_o pulses on the first timeout; no retry logic is built.

Test Plan:
- Basic write: GAP=1, request dat=32'hDEADBEEF at cycle 5, ack_i high in the first WRITE cycle.
  → cycle 6: adr_o=all ones, we_o=1, dat_o=DEADBEEF; cycle 7: done_o=1, bus outputs 0; cycle 8: req_ready_o=1.
- Timeout: TIMEOUT=4, ack_i held 0.
  → WRITE lasts exactly 4 cycles, then err_o=1 for one cycle, bus outputs 0, done_o stays 0.
  → With SIG_WR_RETRY_EN defined: a second 4-cycle WRITE with the same dat_o, then err_o.
- Ack/timeout collision: TIMEOUT=4, ack_i=1 only in the 4th WRITE cycle.
  → done_o=1, err_o=0.
- Back-to-back: req_valid_i held high with GAP=3 and ack_i always 1.
  → successive bus-active cycles are separated by exactly 3 idle cycles plus the IDLE cycle; each write yields one done_o.
- Reset mid-write: rst_ni low in the 2nd WRITE cycle.
  → cyc_o/stb_o/we_o drop in the same cycle without waiting for a clock edge; no done_o/err_o.
  → after release, req_ready_o=1 on the first clock edge.
